// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU run controller and its register-file wrapper.
package cpu_ctrl_pkg;

  // Run-controller state encoding (also the value reported on the state port)
  localparam logic [1:0] ST_RESETTING = 2'd0;
  localparam logic [1:0] ST_HALTED    = 2'd1;
  localparam logic [1:0] ST_RUNNING   = 2'd2;
  localparam logic [1:0] ST_STEPPING  = 2'd3;

  // Host command codes
  localparam logic [1:0] CMD_RESET = 2'd0;
  localparam logic [1:0] CMD_RUN   = 2'd1;
  localparam logic [1:0] CMD_HALT  = 2'd2;
  localparam logic [1:0] CMD_STEP  = 2'd3;

  // Reason the core last entered HALTED
  localparam logic [1:0] CAUSE_NONE       = 2'd0;
  localparam logic [1:0] CAUSE_HOST       = 2'd1;
  localparam logic [1:0] CAUSE_STEP_DONE  = 2'd2;
  localparam logic [1:0] CAUSE_BREAKPOINT = 2'd3;

  // True for the states in which the core may be clocked
  function automatic logic is_active(input logic [1:0] st);
    return (st == ST_RUNNING) || (st == ST_STEPPING);
  endfunction

endpackage

// File: rtl/cpu_run_controller.sv
// Run/halt/step sequencer: drives core reset and clock enable, executes host
// commands, stops on a PC breakpoint and counts executed cycles.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned STEP_W     = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd,
  input  logic [STEP_W-1:0] step_count,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       REGPC,
  output logic              CRST,
  output logic              CEN,
  output logic [1:0]        state,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              done,
  output logic              cmd_err
);

  // One down-counter serves both the reset length and the remaining steps,
  // so it must be wide enough for either.
  localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned CTR_W = (STEP_W > RST_W) ? STEP_W : RST_W;
  localparam logic [CTR_W-1:0] RST_LOAD = CTR_W'(RST_CYCLES);
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q;
  logic             first_q, crst_q, done_q, err_q, err_d;
  logic             active, accept, bp_hit, cen;
  logic [CTR_W-1:0] step_load;

  assign active    = is_active(state_q);
  assign cmd_ready = (state_q != ST_RESETTING);
  assign accept    = cmd_valid & cmd_ready;
  assign bp_hit    = active & bp_en & (REGPC == bp_addr) & ~first_q;
  assign cen       = active & ~bp_hit;
  assign step_load = (step_count == '0) ? CTR_ONE : CTR_W'(step_count);

  // Next state, counter and halt cause; RESET > breakpoint > HALT > step exhaustion
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    cause_d = cause_q;
    err_d   = 1'b0;
    if (accept && cmd == CMD_RESET) begin
      state_d = ST_RESETTING;
      ctr_d   = RST_LOAD;
      cause_d = CAUSE_NONE;
    end else begin
      case (state_q)
        ST_RESETTING: begin
          if (ctr_q == CTR_ONE) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_NONE;
          end else begin
            ctr_d = ctr_q - CTR_ONE;
          end
        end
        ST_HALTED: begin
          if (accept) begin
            case (cmd)
              CMD_RUN:  state_d = ST_RUNNING;
              CMD_STEP: begin
                state_d = ST_STEPPING;
                ctr_d   = step_load;
              end
              default:  err_d = 1'b1;
            endcase
          end
        end
        default: begin
          if (accept && (cmd == CMD_RUN || cmd == CMD_STEP)) err_d = 1'b1;
          if (bp_hit) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_BREAKPOINT;
          end else if (accept && cmd == CMD_HALT) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_HOST;
          end else if (state_q == ST_STEPPING) begin
            // cen is high on this path, so one step is consumed
            ctr_d = ctr_q - CTR_ONE;
            if (ctr_q == CTR_ONE) begin
              state_d = ST_HALTED;
              cause_d = CAUSE_STEP_DONE;
            end
          end
        end
      endcase
    end
  end

  // FSM registers plus registered CRST, first-cycle flag and status pulses
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q <= ST_RESETTING;
      ctr_q   <= RST_LOAD;
      cause_q <= CAUSE_NONE;
      first_q <= 1'b0;
      crst_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      cause_q <= cause_d;
      first_q <= is_active(state_d) & ~active;
      crst_q  <= (state_d == ST_RESETTING);
      done_q  <= active & (state_d == ST_HALTED);
      err_q   <= err_d;
    end
  end

  // Executed-cycle counter: cleared throughout a reset sequence, wraps naturally
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      cnt_q <= '0;
    end else if (state_d == ST_RESETTING) begin
      cnt_q <= '0;
    end else if (cen) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign CRST       = crst_q;
  assign CEN        = cen;
  assign state      = state_q;
  assign halt_cause = cause_q;
  assign cycle_cnt  = cnt_q;
  assign done       = done_q;
  assign cmd_err    = err_q;

endmodule
